serial_tx: RTL

SERIAL_TX -- requirements
Module: serial_tx

---
 rtl/serial_tx.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/serial_tx.sv
// serial_tx: byte-wide write FIFO feeding an 8N1 serial transmitter.
// The line output is registered and follows the frame FSM by one cycle,
// so a byte written at edge N appears as a start bit from edge N+2.
module serial_tx #(
  parameter int unsigned FIFO_AW = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [31:0]        cfg_divider,
  input  logic               wr,
  input  logic [7:0]         data,
  input  logic               clr_ovf,
  output logic               ser_tx,
  output logic               full,
  output logic               empty,
  output logic               busy,
  output logic [FIFO_AW:0]   level,
  output logic               overflow
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned LW    = FIFO_AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t               state_q;
  logic [31:0]          div_q;
  logic [31:0]          cnt_q;
  logic [2:0]           bit_idx_q;
  logic [7:0]           shift_q;

  logic [7:0]           mem_q [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr_q;
  logic [FIFO_AW-1:0]   rd_ptr_q;

  logic                 bit_end_c;
  logic [31:0]          div_eff_c;
  logic                 pop_c;
  logic                 push_c;
  logic [FIFO_AW:0]     level_d;

  // Bit timing, FIFO handshake and next occupancy.
  always_comb begin
    bit_end_c = (cnt_q == (div_q - 32'd1));
    div_eff_c = (cfg_divider < 32'd2) ? 32'd2 : cfg_divider;
    pop_c     = !empty && ((state_q == S_IDLE) ||
                           ((state_q == S_STOP) && bit_end_c));
    push_c    = reset_n && wr && !full;
    level_d   = level + LW'(push_c) - LW'(pop_c);
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= data;
  end

  // FIFO pointers, status flags and sticky overflow.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      level <= level_d;
      empty <= (level_d == LW'(0));
      full  <= (level_d == LW'(DEPTH));
      // A dropped write wins over a simultaneous clear.
      if (wr && full)   overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
      // Busy covers the line still showing a frame (one cycle behind state).
      busy <= (state_q != S_IDLE) || pop_c || (level_d != LW'(0));
    end
  end

  // Frame FSM; ser_tx is the registered line level of the current state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      ser_tx    <= 1'b1;
      div_q     <= 32'd2;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ser_tx <= 1'b1;
          if (pop_c) begin
            shift_q <= mem_q[rd_ptr_q];
            div_q   <= div_eff_c;
            cnt_q   <= '0;
            state_q <= S_START;
          end
        end
        S_START: begin
          ser_tx <= 1'b0;
          if (bit_end_c) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            state_q   <= S_DATA;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        S_DATA: begin
          ser_tx <= shift_q[0];
          if (bit_end_c) begin
            cnt_q   <= '0;
            shift_q <= {1'b0, shift_q[7:1]};
            if (bit_idx_q == 3'd7) state_q <= S_STOP;
            else                   bit_idx_q <= bit_idx_q + 3'd1;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        S_STOP: begin
          ser_tx <= 1'b1;
          if (bit_end_c) begin
            cnt_q <= '0;
            if (pop_c) begin
              shift_q <= mem_q[rd_ptr_q];
              div_q   <= div_eff_c;
              state_q <= S_START;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
